// File: rtl/retire_pair_checker_if.sv
// Retire bundle from the two-core clock synchroniser into retire_pair_checker.
// Holds the pair-retire strobe, per-core port selects and the four RVFI commit ports.
interface retire_pair_checker_if #(
    parameter int XLEN = 32
);
    logic            retire;
    logic            sel_1;
    logic            sel_2;
    logic            valid_1_1, valid_1_2, valid_2_1, valid_2_2;
    logic [XLEN-1:0] pc_rdata_1_1, pc_rdata_1_2, pc_rdata_2_1, pc_rdata_2_2;
    logic [31:0]     insn_1_1, insn_1_2, insn_2_1, insn_2_2;
    logic [XLEN-1:0] mem_addr_1_1, mem_addr_1_2, mem_addr_2_1, mem_addr_2_2;

    modport master (
        output retire, sel_1, sel_2,
        output valid_1_1, valid_1_2, valid_2_1, valid_2_2,
        output pc_rdata_1_1, pc_rdata_1_2, pc_rdata_2_1, pc_rdata_2_2,
        output insn_1_1, insn_1_2, insn_2_1, insn_2_2,
        output mem_addr_1_1, mem_addr_1_2, mem_addr_2_1, mem_addr_2_2
    );

    modport slave (
        input retire, sel_1, sel_2,
        input valid_1_1, valid_1_2, valid_2_1, valid_2_2,
        input pc_rdata_1_1, pc_rdata_1_2, pc_rdata_2_1, pc_rdata_2_2,
        input insn_1_1, insn_1_2, insn_2_1, insn_2_2,
        input mem_addr_1_1, mem_addr_1_2, mem_addr_2_1, mem_addr_2_2
    );
endinterface

// File: rtl/retire_pair_checker.sv
// Two-stage retired-pair comparator with sticky PASS/FAIL verdict for the relational harness.
// Define RETIRE_CHECK_MEM_ADDR_EN to also compare the selected ports' memory addresses.
module retire_pair_checker #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int MAX_RETIRE = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    retire_pair_checker_if.slave bus,
    output logic                 mismatch_o,
    output logic                 fail_o,
    output logic                 pass_o,
    output logic                 proto_err_o,
    output logic [CNT_W-1:0]     count_o,
    output logic [XLEN-1:0]      first_bad_pc_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FAIL = 2'd2;
    localparam logic [1:0] PASS = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             s1Valid_q, s1Valid_d;
    logic             s1Proto_q, s1Proto_d;
    logic [XLEN-1:0]  s1Pc1_q, s1Pc1_d, s1Pc2_q, s1Pc2_d;
    logic [31:0]      s1Insn1_q, s1Insn1_d, s1Insn2_q, s1Insn2_d;
    logic             mismatch_q, mismatch_d;
    logic             protoErr_q, protoErr_d;
    logic [CNT_W-1:0] count_q, count_d, countInc;
    logic [XLEN-1:0]  badPc_q, badPc_d;
    logic             addrDiff;
    logic             pairDiff;

`ifdef RETIRE_CHECK_MEM_ADDR_EN
    logic [XLEN-1:0] s1Addr1_q, s1Addr2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Addr1_q <= '0;
            s1Addr2_q <= '0;
        end else if (s1Valid_d) begin
            s1Addr1_q <= bus.sel_1 ? bus.mem_addr_1_2 : bus.mem_addr_1_1;
            s1Addr2_q <= bus.sel_2 ? bus.mem_addr_2_2 : bus.mem_addr_2_1;
        end
    end

    assign addrDiff = (s1Addr1_q != s1Addr2_q);
`else
    logic unusedMemAddr;
    assign unusedMemAddr = ^{bus.mem_addr_1_1, bus.mem_addr_1_2, bus.mem_addr_2_1, bus.mem_addr_2_2};
    assign addrDiff      = 1'b0;
`endif

    assign pairDiff = (s1Pc1_q != s1Pc2_q) || (s1Insn1_q != s1Insn2_q) || addrDiff;
    assign countInc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    // S2 resolution: a protocol error outranks a data mismatch, and FAIL outranks reaching MAX_RETIRE.
    always_comb begin
        state_d    = state_q;
        mismatch_d = 1'b0;
        protoErr_d = protoErr_q;
        count_d    = count_q;
        badPc_d    = badPc_q;
        if (s1Valid_q) begin
            count_d = countInc;
            if (s1Proto_q) begin
                state_d    = FAIL;
                protoErr_d = 1'b1;
                badPc_d    = '0;
            end else if (pairDiff) begin
                state_d    = FAIL;
                mismatch_d = 1'b1;
                badPc_d    = s1Pc1_q;
            end else if (MAX_RETIRE != 0 && countInc == CNT_W'(MAX_RETIRE)) begin
                state_d = PASS;
            end else begin
                state_d = RUN;
            end
        end
    end

    // A retire landing on the edge that enters a terminal state is dropped along with later ones.
    always_comb begin
        s1Valid_d = bus.retire && (state_d == IDLE || state_d == RUN);
        s1Proto_d = !((bus.sel_1 ? bus.valid_1_2 : bus.valid_1_1) &&
                      (bus.sel_2 ? bus.valid_2_2 : bus.valid_2_1));
        s1Pc1_d   = bus.sel_1 ? bus.pc_rdata_1_2 : bus.pc_rdata_1_1;
        s1Pc2_d   = bus.sel_2 ? bus.pc_rdata_2_2 : bus.pc_rdata_2_1;
        s1Insn1_d = bus.sel_1 ? bus.insn_1_2 : bus.insn_1_1;
        s1Insn2_d = bus.sel_2 ? bus.insn_2_2 : bus.insn_2_1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            s1Valid_q  <= 1'b0;
            s1Proto_q  <= 1'b0;
            s1Pc1_q    <= '0;
            s1Pc2_q    <= '0;
            s1Insn1_q  <= '0;
            s1Insn2_q  <= '0;
            mismatch_q <= 1'b0;
            protoErr_q <= 1'b0;
            count_q    <= '0;
            badPc_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1Valid_q  <= s1Valid_d;
            mismatch_q <= mismatch_d;
            protoErr_q <= protoErr_d;
            count_q    <= count_d;
            badPc_q    <= badPc_d;
            if (s1Valid_d) begin
                s1Proto_q <= s1Proto_d;
                s1Pc1_q   <= s1Pc1_d;
                s1Pc2_q   <= s1Pc2_d;
                s1Insn1_q <= s1Insn1_d;
                s1Insn2_q <= s1Insn2_d;
            end
        end
    end

    assign mismatch_o     = mismatch_q;
    assign fail_o         = (state_q == FAIL);
    assign pass_o         = (state_q == PASS);
    assign proto_err_o    = protoErr_q;
    assign count_o        = count_q;
    assign first_bad_pc_o = badPc_q;

endmodule
